// File: rtl/alu_wb_buffer.sv
// ALU writeback buffer: in-order FIFO between ALU completion and the CDB arbiter.
// Optional same-cycle bypass of alu_in to the CDB when empty: define ALU_WB_BYPASS_EN.

package types_pkg;
  typedef struct packed {
    logic        fu_alu_done;
    logic [6:0]  p_alu;
    logic [4:0]  rob_fu_alu;
    logic [31:0] data;
  } alu_data;
endpackage

module alu_wb_buffer
  import types_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PD_W  = 7,
  parameter int unsigned ROB_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  alu_data          alu_in,
  input  logic             flush,
  input  logic             cdb_grant,
  output logic             cdb_valid,
  output logic [PD_W-1:0]  cdb_pd,
  output logic             cdb_prf_we,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [31:0]      cdb_data,
  output logic             alu_wb_ready,
  output logic             overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PD_W-1:0]  pd_mem   [DEPTH];
  logic [ROB_W-1:0] rob_mem  [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q;

  logic fifo_valid, full, push, pop, ovf_set, byp;
  logic [PD_W-1:0]  in_pd;
  logic [ROB_W-1:0] in_rob;

  assign in_pd      = PD_W'(alu_in.p_alu);
  assign in_rob     = ROB_W'(alu_in.rob_fu_alu);
  assign fifo_valid = (count_q != '0);
  assign full       = (count_q == CntW'(DEPTH));

`ifdef ALU_WB_BYPASS_EN
  assign byp = !fifo_valid && alu_in.fu_alu_done;
`else
  assign byp = 1'b0;
`endif

  // A bypassed result granted this cycle is consumed and never enters the FIFO.
  assign pop     = !flush && fifo_valid && cdb_grant;
  assign push    = !flush && alu_in.fu_alu_done && !(byp && cdb_grant) && (!full || pop);
  assign ovf_set = !flush && alu_in.fu_alu_done && full && !pop;

  // Reserve one slot for the result already in flight from the ALU.
  assign alu_wb_ready = (count_q < CntW'(DEPTH - 1));
  assign overflow     = overflow_q;

  always_comb begin
    cdb_valid  = !flush && (fifo_valid || byp);
    cdb_pd     = '0;
    cdb_rob    = '0;
    cdb_data   = '0;
    if (cdb_valid) begin
      if (fifo_valid) begin
        cdb_pd   = pd_mem[head_q];
        cdb_rob  = rob_mem[head_q];
        cdb_data = data_mem[head_q];
      end else begin
        cdb_pd   = in_pd;
        cdb_rob  = in_rob;
        cdb_data = alu_in.data;
      end
    end
    cdb_prf_we = cdb_valid && (cdb_pd != '0);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_q | ovf_set;
    end
  end

  // Storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pd_mem[tail_q]   <= in_pd;
      rob_mem[tail_q]  <= in_rob;
      data_mem[tail_q] <= alu_in.data;
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed self-checking bench for alu_wb_buffer (default build, no bypass).

module tb_alu_wb_buffer;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  alu_data     alu_in;
  logic        flush;
  logic        cdb_grant;
  logic        cdb_valid;
  logic [6:0]  cdb_pd;
  logic        cdb_prf_we;
  logic [4:0]  cdb_rob;
  logic [31:0] cdb_data;
  logic        alu_wb_ready;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_wb_buffer #(.DEPTH(4), .PD_W(7), .ROB_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_in       (alu_in),
    .flush        (flush),
    .cdb_grant    (cdb_grant),
    .cdb_valid    (cdb_valid),
    .cdb_pd       (cdb_pd),
    .cdb_prf_we   (cdb_prf_we),
    .cdb_rob      (cdb_rob),
    .cdb_data     (cdb_data),
    .alu_wb_ready (alu_wb_ready),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input logic [6:0] pd, input logic [4:0] rob, input logic [31:0] d);
    alu_in.fu_alu_done = 1'b1;
    alu_in.p_alu       = pd;
    alu_in.rob_fu_alu  = rob;
    alu_in.data        = d;
  endtask

  task automatic clr_done();
    alu_in = '0;
  endtask

  task automatic push_one(input logic [6:0] pd, input logic [4:0] rob, input logic [31:0] d);
    set_done(pd, rob, d);
    cycle();
    clr_done();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    alu_in    = '0;
    flush     = 1'b0;
    cdb_grant = 1'b0;
    reset     = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(cdb_valid), 32'd0);
    check("rst_pd", 32'(cdb_pd), 32'd0);
    check("rst_prf_we", 32'(cdb_prf_we), 32'd0);
    check("rst_rob", 32'(cdb_rob), 32'd0);
    check("rst_data", cdb_data, 32'd0);
    check("rst_ready", 32'(alu_wb_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single done with grant held: valid exactly one cycle at C+1
    cdb_grant = 1'b1;
    set_done(7'd5, 5'd3, 32'h0000_000F);
    #1;
    check("single_c_valid", 32'(cdb_valid), 32'd0);
    cycle();
    clr_done();
    #1;
    check("single_valid", 32'(cdb_valid), 32'd1);
    check("single_pd", 32'(cdb_pd), 32'd5);
    check("single_rob", 32'(cdb_rob), 32'd3);
    check("single_data", cdb_data, 32'h0000_000F);
    check("single_prf_we", 32'(cdb_prf_we), 32'd1);
    cycle();
    check("single_after", 32'(cdb_valid), 32'd0);
    cdb_grant = 1'b0;

    // Four back-to-back, ready drops after the third push, then drain in order
    for (int i = 0; i < 4; i++) begin
      push_one(7'(i + 1), 5'(i + 8), 32'(i + 1));
      check($sformatf("b2b_ready_%0d", i), 32'(alu_wb_ready), (i + 1 < 3) ? 32'd1 : 32'd0);
    end
    cdb_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("b2b_valid_%0d", i), 32'(cdb_valid), 32'd1);
      check($sformatf("b2b_data_%0d", i), cdb_data, 32'(i + 1));
      check($sformatf("b2b_rob_%0d", i), 32'(cdb_rob), 32'(i + 8));
      cycle();
    end
    check("b2b_empty_valid", 32'(cdb_valid), 32'd0);
    check("b2b_empty_ready", 32'(alu_wb_ready), 32'd1);
    cdb_grant = 1'b0;

    // Overflow: fifth done into a full buffer is dropped
    for (int i = 0; i < 4; i++) push_one(7'd1, 5'd0, 32'h10 + 32'(i));
    check("ovf_before", 32'(overflow), 32'd0);
    push_one(7'd1, 5'd0, 32'h99);
    check("ovf_set", 32'(overflow), 32'd1);
    cdb_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("ovf_data_%0d", i), cdb_data, 32'h10 + 32'(i));
      cycle();
    end
    check("ovf_drained", 32'(cdb_valid), 32'd0);
    cdb_grant = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("ovf_after_flush", 32'(overflow), 32'd1);
    do_reset();
    check("ovf_after_reset", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) push_one(7'd2, 5'd0, 32'h20 + 32'(i));
    set_done(7'd2, 5'd0, 32'h24);
    cdb_grant = 1'b1;
    #1;
    check("fullpp_head", cdb_data, 32'h20);
    cycle();
    clr_done();
    cdb_grant = 1'b0;
    #1;
    check("fullpp_overflow", 32'(overflow), 32'd0);
    check("fullpp_ready", 32'(alu_wb_ready), 32'd0);
    cdb_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fullpp_data_%0d", i), cdb_data, 32'h21 + 32'(i));
      cycle();
    end
    check("fullpp_empty", 32'(cdb_valid), 32'd0);
    cdb_grant = 1'b0;

    // Flush with concurrent done and grant
    for (int i = 0; i < 3; i++) push_one(7'd3, 5'd0, 32'h30 + 32'(i));
    flush = 1'b1;
    cdb_grant = 1'b1;
    set_done(7'd3, 5'd0, 32'h33);
    #1;
    check("flush_cycle_valid", 32'(cdb_valid), 32'd0);
    cycle();
    flush = 1'b0;
    cdb_grant = 1'b0;
    clr_done();
    #1;
    check("flush_valid", 32'(cdb_valid), 32'd0);
    check("flush_ready", 32'(alu_wb_ready), 32'd1);
    push_one(7'd3, 5'd1, 32'h40);
    check("flush_new_head", cdb_data, 32'h40);
    cdb_grant = 1'b1;
    cycle();
    check("flush_count_zero", 32'(cdb_valid), 32'd0);
    cdb_grant = 1'b0;

    // pd = 0 completes in the ROB without a PRF write
    push_one(7'd0, 5'd7, 32'hDEAD_BEEF);
    check("pd0_valid", 32'(cdb_valid), 32'd1);
    check("pd0_rob", 32'(cdb_rob), 32'd7);
    check("pd0_prf_we", 32'(cdb_prf_we), 32'd0);
    check("pd0_data", cdb_data, 32'hDEAD_BEEF);
    cdb_grant = 1'b1;
    cycle();
    check("pd0_popped", 32'(cdb_valid), 32'd0);
    cdb_grant = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
# alu_wb_buffer

Writeback buffer on the consumer side of the ALU completion interface. Captures every `alu_data` result the ALU functional unit reports with `fu_alu_done`, queues it in a small in-order FIFO, and presents one result per cycle to the common data bus (PRF write port plus ROB completion) under a valid/grant handshake from the CDB arbiter. Back-pressures the issue stage through `alu_wb_ready` so the ALU never completes into a full buffer. Supports a pipeline flush on branch mispredict.

## Interface
- `DEPTH`, 4: FIFO entries; a power of two, ≥2.
- `PD_W`, 7: physical register tag width.
- `ROB_W`, 5: ROB index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alu_in`  in  `alu_data` (types_pkg)  ALU completion; fields used: `fu_alu_done`, `p_alu`[PD_W], `rob_fu_alu`[ROB_W], `data`[32].
- `flush`  in  1  mispredict flush; discards all buffered and arriving results.
- `cdb_grant`  in  1  arbiter accepts the current head this cycle.
- `cdb_valid`  out  1  head result is presented.
- `cdb_pd`  out  PD_W  destination physical register.
- `cdb_prf_we`  out  1  PRF write enable; equals `cdb_valid && cdb_pd != 0`.
- `cdb_rob`  out  ROB_W  ROB index to mark complete.
- `cdb_data`  out  32  result value.
- `alu_wb_ready`  out  1  issue permitted to ALU this cycle.
- `overflow`  out  1  sticky error: a completion arrived while full with no pop.

## Operation
- Storage: circular FIFO of `DEPTH` entries {pd, rob, data}; head pointer, tail pointer, count of width clog2(DEPTH+1). Pointers wrap modulo DEPTH.
- Push: in a cycle where `alu_in.fu_alu_done` is high, the entry is written at the tail on the closing edge, unless it is consumed by bypass (see Configuration) or dropped by flush/overflow.
- Pop: in a cycle where `cdb_valid && cdb_grant`, the head advances on the closing edge. `cdb_grant` without `cdb_valid` is ignored.
- Outputs `cdb_pd/cdb_rob/cdb_data` are driven from the head entry; when `cdb_valid` is low they are 0.
- Simultaneous push and pop: both happen; count is unchanged. This holds when full, because the pop frees a slot in the same edge.
- Full with push and no pop: the arriving result is dropped, FIFO contents are unchanged, and `overflow` sets and holds until reset.
- `alu_wb_ready` = (count < DEPTH-1), which leaves one slot for a result already in flight (ALU issue→done is one cycle).
- pd = 0: the result still completes in the ROB (`cdb_valid` high) with `cdb_prf_we` low.
- Flush: on the closing edge of a cycle with `flush` high, head, tail, and count go to 0. A push or bypass in that same cycle is discarded, so `cdb_valid` is forced low during the flush cycle. A concurrent grant has no effect. `overflow` is not cleared by flush.
- Reset has the same effect as flush and also clears `overflow`. Reset takes priority over every other input.

## Timing
- Reset values: `cdb_valid`=0, `cdb_pd`=0, `cdb_prf_we`=0, `cdb_rob`=0, `cdb_data`=0, `alu_wb_ready`=1, `overflow`=0.
- Latency without bypass: done in cycle C → `cdb_valid` in cycle C+1 if the buffer was empty; otherwise the result waits behind the older entries.
- Throughput: one result per cycle in both directions.
- `alu_wb_ready` is a function of registered count only; there is no combinational path from `cdb_grant` to `alu_wb_ready`.
- Results are broadcast strictly in arrival order.

## Configuration
- `ALU_WB_BYPASS_EN` defined: when count = 0 and `fu_alu_done` is high, `alu_in` drives the CDB outputs combinationally in the same cycle C.
  - If `cdb_grant` is high in C, the entry is not pushed.
  - Otherwise it is pushed and presented from the FIFO in C+1.
- `ALU_WB_BYPASS_EN` undefined: no combinational path from `alu_in` to any output; minimum latency is one cycle.

## Test plan
- Reset, then a single done (pd=5, rob=3, data=0x0000000F) with `cdb_grant` held high → `cdb_valid` for exactly one cycle at C+1 (C with bypass), with pd=5, rob=3, data=0x0F and `cdb_prf_we`=1.
- Four back-to-back dones (data 1, 2, 3, 4) with grant low → `alu_wb_ready` drops after the third push; then raise grant → outputs 1, 2, 3, 4 in order on consecutive cycles, after which `cdb_valid`=0 and `alu_wb_ready`=1.
- Fill to DEPTH=4, then a fifth done with grant low → entries unchanged, `overflow`=1 and still 1 after a flush.
- Full buffer with done and grant in the same cycle → head popped, new entry appended, count stays 4, `overflow` stays 0.
- Three entries buffered, then `flush` together with a done and a grant → next cycle `cdb_valid`=0, count=0, `alu_wb_ready`=1.
- Done with pd=0, rob=7, data=0xDEADBEEF → `cdb_valid`=1, `cdb_rob`=7, `cdb_prf_we`=0.
